// File: rtl/env_sup_pkg.sv
// Shared types and default thresholds for the environmental-condition supervisor.
package env_sup_pkg;

  typedef enum logic [1:0] {
    LVL_NORMAL  = 2'd0,
    LVL_CAUTION = 2'd1,
    LVL_SEVERE  = 2'd2,
    LVL_EMERG   = 2'd3
  } level_e;

  localparam int DEF_WIND_W       = 6;
  localparam int DEF_TEMP_W       = 8;
  localparam int DEF_DEBOUNCE     = 3;
  localparam int DEF_WIND_CAUTION = 10;
  localparam int DEF_WIND_SEVERE  = 15;
  localparam int DEF_WIND_EMERG   = 20;
  localparam int DEF_TEMP_SEVERE  = 35;
  localparam int DEF_TEMP_EMERG   = 40;
  localparam int DEF_CNT_W        = 8;

  function automatic level_e lvl_dec(input level_e l);
    return level_e'(l - 2'd1);
  endfunction

endpackage

// File: rtl/env_sup_classifier.sv
// Combinational mapping of one sensor sample onto a hazard level.
module env_classifier
  import env_sup_pkg::*;
#(
  parameter int WIND_W       = DEF_WIND_W,
  parameter int TEMP_W       = DEF_TEMP_W,
  parameter int WIND_CAUTION = DEF_WIND_CAUTION,
  parameter int WIND_SEVERE  = DEF_WIND_SEVERE,
  parameter int WIND_EMERG   = DEF_WIND_EMERG,
  parameter int TEMP_SEVERE  = DEF_TEMP_SEVERE,
  parameter int TEMP_EMERG   = DEF_TEMP_EMERG
) (
  input  logic                     thunderstorm_i,
  input  logic [WIND_W-1:0]        wind_i,
  input  logic [1:0]               vis_i,
  input  logic signed [TEMP_W-1:0] temp_i,
  output level_e                   level_o
);

  // Both operands signed so the temperature comparisons stay two's complement.
  localparam logic signed [TEMP_W-1:0] T_SEV_HI = TEMP_W'(TEMP_SEVERE);
  localparam logic signed [TEMP_W-1:0] T_SEV_LO = TEMP_W'(-TEMP_SEVERE);
  localparam logic signed [TEMP_W-1:0] T_EMG_HI = TEMP_W'(TEMP_EMERG);
  localparam logic signed [TEMP_W-1:0] T_EMG_LO = TEMP_W'(-TEMP_EMERG);
  localparam logic [WIND_W-1:0] W_CAU = WIND_W'(WIND_CAUTION);
  localparam logic [WIND_W-1:0] W_SEV = WIND_W'(WIND_SEVERE);
  localparam logic [WIND_W-1:0] W_EMG = WIND_W'(WIND_EMERG);

  logic is_emerg, is_severe, is_caution;

  always_comb begin
    is_emerg   = (temp_i < T_EMG_LO) || (temp_i > T_EMG_HI) || (wind_i > W_EMG);
    is_severe  = thunderstorm_i || (temp_i < T_SEV_LO) || (temp_i > T_SEV_HI) ||
                 (wind_i > W_SEV) || (vis_i == 2'd3);
    is_caution = (wind_i > W_CAU) || (vis_i == 2'd1) || (vis_i == 2'd2);
    level_o    = LVL_NORMAL;
    if (is_emerg)        level_o = LVL_EMERG;
    else if (is_severe)  level_o = LVL_SEVERE;
    else if (is_caution) level_o = LVL_CAUTION;
  end

endmodule

// File: rtl/env_cond_supervisor.sv
// Hazard-level FSM with debounced de-escalation and emergency-entry counter.
// Optional ENV_SUP_ACK_EN: crew ack may release EMERGENCY down to SEVERE.
module env_cond_supervisor
  import env_sup_pkg::*;
#(
  parameter int WIND_W       = DEF_WIND_W,
  parameter int TEMP_W       = DEF_TEMP_W,
  parameter int DEBOUNCE     = DEF_DEBOUNCE,
  parameter int WIND_CAUTION = DEF_WIND_CAUTION,
  parameter int WIND_SEVERE  = DEF_WIND_SEVERE,
  parameter int WIND_EMERG   = DEF_WIND_EMERG,
  parameter int TEMP_SEVERE  = DEF_TEMP_SEVERE,
  parameter int TEMP_EMERG   = DEF_TEMP_EMERG,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     sample_valid,
  input  logic                     thunderstorm,
  input  logic [WIND_W-1:0]        wind,
  input  logic [1:0]               visibility,
  input  logic signed [TEMP_W-1:0] temperature,
  input  logic                     ack,
  output logic [1:0]               state,
  output logic                     severe_weather,
  output logic                     emergency_landing_alert,
  output logic                     state_changed,
  output logic [CNT_W-1:0]         emerg_count
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  level_e            lvl;
  level_e            state_q, state_d;
  logic [DB_W-1:0]   deb_q, deb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              severe_q, alert_q, chg_q;

  env_classifier #(
    .WIND_W(WIND_W), .TEMP_W(TEMP_W),
    .WIND_CAUTION(WIND_CAUTION), .WIND_SEVERE(WIND_SEVERE), .WIND_EMERG(WIND_EMERG),
    .TEMP_SEVERE(TEMP_SEVERE), .TEMP_EMERG(TEMP_EMERG)
  ) u_cls (
    .thunderstorm_i(thunderstorm),
    .wind_i        (wind),
    .vis_i         (visibility),
    .temp_i        (temperature),
    .level_o       (lvl)
  );

`ifndef ENV_SUP_ACK_EN
  logic ack_unused;
  assign ack_unused = ack;
`endif

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    if (sample_valid) begin
      if (state_q == LVL_EMERG) begin
`ifdef ENV_SUP_ACK_EN
        if (ack && (lvl != LVL_EMERG)) begin
          state_d = LVL_SEVERE;
          deb_d   = '0;
        end
`endif
      end else if (lvl > state_q) begin
        state_d = lvl;
        deb_d   = '0;
      end else if (lvl < state_q) begin
        // Only step one level per completed run, regardless of how low the sample is.
        if (deb_q == DB_LAST) begin
          state_d = lvl_dec(state_q);
          deb_d   = '0;
        end else begin
          deb_d = deb_q + DB_W'(1);
        end
      end else begin
        deb_d = '0;
      end
    end
    if ((state_d == LVL_EMERG) && (state_q != LVL_EMERG) && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= LVL_NORMAL;
      deb_q    <= '0;
      cnt_q    <= '0;
      severe_q <= 1'b0;
      alert_q  <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      severe_q <= (state_d >= LVL_SEVERE);
      alert_q  <= (state_d == LVL_EMERG);
      chg_q    <= (state_d != state_q);
    end
  end

  assign state                   = state_q;
  assign severe_weather          = severe_q;
  assign emergency_landing_alert = alert_q;
  assign state_changed           = chg_q;
  assign emerg_count             = cnt_q;

endmodule

// File: tb/tb_env_cond_supervisor.sv
// Self-checking bench for env_cond_supervisor: directed scenarios plus random
// samples compared against a rule-level reference model.
module tb_env_cond_supervisor;

  localparam int DEBOUNCE = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              sample_valid = 1'b0;
  logic              thunderstorm = 1'b0;
  logic [5:0]        wind = '0;
  logic [1:0]        visibility = '0;
  logic signed [7:0] temperature = '0;
  logic              ack = 1'b0;
  logic [1:0]        state;
  logic              severe_weather, emergency_landing_alert, state_changed;
  logic [7:0]        emerg_count;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_state = 0, m_run = 0, m_cnt = 0, m_chg = 0;

  env_cond_supervisor dut (
    .CLK(CLK), .RST(RST), .sample_valid(sample_valid), .thunderstorm(thunderstorm),
    .wind(wind), .visibility(visibility), .temperature(temperature), .ack(ack),
    .state(state), .severe_weather(severe_weather),
    .emergency_landing_alert(emergency_landing_alert), .state_changed(state_changed),
    .emerg_count(emerg_count)
  );

  always #5 CLK = ~CLK;

  function automatic int classify(input bit ts, input int w, input int vis, input int t);
    if (t < -40 || t > 40 || w > 20) return 3;
    if (ts || t < -35 || t > 35 || w > 15 || vis == 3) return 2;
    if (w > 10 || vis == 1 || vis == 2) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_run = 0; m_cnt = 0; m_chg = 0;
  endtask

  // Drives one sample for one clock, advances the model, returns #1 after the edge.
  task automatic apply(input bit v, input bit ts, input int w, input int vis,
                       input int t, input bit a);
    int lvl, prev;
    @(negedge CLK);
    sample_valid = v; thunderstorm = ts; wind = 6'(w); visibility = 2'(vis);
    temperature = 8'(t); ack = a;
    prev = m_state;
    if (v) begin
      lvl = classify(ts, w, vis, t);
      if (m_state == 3) begin
`ifdef ENV_SUP_ACK_EN
        if (a && lvl < 3) begin m_state = 2; m_run = 0; end
`endif
      end else if (lvl > m_state) begin
        m_state = lvl; m_run = 0;
      end else if (lvl < m_state) begin
        m_run++;
        if (m_run == DEBOUNCE) begin m_state--; m_run = 0; end
      end else begin
        m_run = 0;
      end
    end
    m_chg = (m_state != prev) ? 1 : 0;
    if (m_state == 3 && prev != 3 && m_cnt < 255) m_cnt++;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; sample_valid = 0; ack = 0;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    RST = 1'b1; #2;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (severe_weather !== 1'b0) begin failures++; $display("FAIL reset_severe got=%b exp=0", severe_weather); end
    checks++; if (emergency_landing_alert !== 1'b0) begin failures++; $display("FAIL reset_alert got=%b exp=0", emergency_landing_alert); end
    checks++; if (state_changed !== 1'b0) begin failures++; $display("FAIL reset_chg got=%b exp=0", state_changed); end
    checks++; if (emerg_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", emerg_count); end
    do_reset();
  endtask

  task automatic test_escalate();
    do_reset();
    apply(1, 0, 12, 0, 20, 0);
    checks++; if (state !== 2'd1 || state_changed !== 1'b1) begin failures++; $display("FAIL esc_caution state=%0d chg=%b exp=1/1", state, state_changed); end
    apply(0, 0, 30, 0, 20, 0);
    checks++; if (state !== 2'd1 || state_changed !== 1'b0) begin failures++; $display("FAIL esc_hold state=%0d chg=%b exp=1/0", state, state_changed); end
    apply(1, 0, 0, 0, -36, 0);
    checks++; if (state !== 2'd2 || severe_weather !== 1'b1) begin failures++; $display("FAIL esc_severe state=%0d sev=%b exp=2/1", state, severe_weather); end
    apply(1, 0, 0, 0, -41, 0);
    checks++; if (state !== 2'd3 || emergency_landing_alert !== 1'b1 || emerg_count !== 8'd1) begin
      failures++; $display("FAIL esc_emerg state=%0d alert=%b cnt=%0d exp=3/1/1", state, emergency_landing_alert, emerg_count); end
    do_reset();
    apply(1, 0, 25, 0, 0, 0);
    checks++; if (state !== 2'd3 || state_changed !== 1'b1) begin failures++; $display("FAIL esc_skip state=%0d chg=%b exp=3/1", state, state_changed); end
  endtask

  task automatic test_debounce();
    do_reset();
    apply(1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL deb_two_clear got=%0d exp=2", state); end
    apply(1, 0, 0, 0, 0, 0);
    checks++; if (state !== 2'd1 || state_changed !== 1'b1) begin failures++; $display("FAIL deb_drop state=%0d chg=%b exp=1/1", state, state_changed); end
    apply(1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    apply(1, 0, 16, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL deb_restart got=%0d exp=2", state); end
    apply(1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL deb_after_restart got=%0d exp=1", state); end
  endtask

  task automatic test_emergency_ack();
    do_reset();
    apply(1, 0, 25, 0, 0, 0);
    apply(1, 0, 25, 0, 0, 1);
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL ack_emerg_sample got=%0d exp=3", state); end
    apply(0, 0, 0, 0, 0, 1);
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL ack_invalid got=%0d exp=3", state); end
    apply(1, 0, 0, 0, 0, 1);
`ifdef ENV_SUP_ACK_EN
    checks++; if (state !== 2'd2 || emergency_landing_alert !== 1'b0) begin failures++; $display("FAIL ack_release state=%0d alert=%b exp=2/0", state, emergency_landing_alert); end
`else
    checks++; if (state !== 2'd3 || emergency_landing_alert !== 1'b1) begin failures++; $display("FAIL ack_absorb state=%0d alert=%b exp=3/1", state, emergency_landing_alert); end
`endif
    do_reset();
    apply(1, 0, 12, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 1);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL ack_outside got=%0d exp=1", state); end
  endtask

  task automatic test_boundaries();
    do_reset();
    apply(1, 0, 15, 0, 35, 0);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL bnd_w15_t35 got=%0d exp=1", state); end
    do_reset();
    apply(1, 0, 15, 0, -35, 0);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL bnd_w15_tm35 got=%0d exp=1", state); end
    do_reset();
    apply(1, 0, 10, 0, 0, 0);
    checks++; if (state !== 2'd0 || state_changed !== 1'b0) begin failures++; $display("FAIL bnd_w10 state=%0d chg=%b exp=0/0", state, state_changed); end
    apply(1, 0, 20, 0, 40, 0);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL bnd_w20_t40 got=%0d exp=2", state); end
    apply(1, 0, 0, 0, -40, 0);
    apply(1, 0, 0, 0, -127, 0);
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL bnd_tneg_big got=%0d exp=3", state); end
  endtask

  task automatic test_async_reset();
    do_reset();
    apply(1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    #2 RST = 1'b1;
    #1;
    checks++; if (state !== 2'd0 || severe_weather !== 1'b0 || state_changed !== 1'b0 || emerg_count !== 8'd0) begin
      failures++; $display("FAIL async_rst state=%0d sev=%b chg=%b cnt=%0d exp=0", state, severe_weather, state_changed, emerg_count); end
    @(negedge CLK); RST = 1'b0;
    model_reset();
    apply(1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL rst_cleared_deb got=%0d exp=2", state); end
  endtask

  task automatic test_random();
    int w, t, vis;
    bit v, ts, a;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      v   = ($urandom_range(0, 3) != 0);
      ts  = ($urandom_range(0, 9) == 0);
      w   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(8, 22);
      t   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) - 128 : $urandom_range(0, 90) - 45;
      vis = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0;
      a   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin ts = 0; w = $urandom_range(0, 10); t = $urandom_range(0, 60) - 30; vis = 0; end
      apply(v, ts, w, vis, t, a);
      checks++;
      if (state !== 2'(m_state) || severe_weather !== (m_state >= 2) ||
          emergency_landing_alert !== (m_state == 3) || state_changed !== m_chg[0] ||
          emerg_count !== 8'(m_cnt)) begin
        failures++;
        $display("FAIL rand_%0d state=%0d/%0d sev=%b alert=%b chg=%b/%0d cnt=%0d/%0d",
                 i, state, m_state, severe_weather, emergency_landing_alert,
                 state_changed, m_chg, emerg_count, m_cnt);
      end
    end
  endtask

`ifdef ENV_SUP_ACK_EN
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 258; i++) begin
      apply(1, 0, 30, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 1);
    end
    checks++; if (emerg_count !== 8'd255) begin failures++; $display("FAIL cnt_saturate got=%0d exp=255", emerg_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_escalate();
    test_debounce();
    test_emergency_ack();
    test_boundaries();
    test_async_reset();
`ifdef ENV_SUP_ACK_EN
    test_saturation();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/env_cond_supervisor.md
ENV_COND_SUPERVISOR -- requirements
Module: env_cond_supervisor

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
  WIND_W, 6, wind sample width (unsigned)
  TEMP_W, 8, temperature sample width (signed two's complement)
  DEBOUNCE, 3, consecutive lower-level samples required to de-escalate one level (>=1)
  WIND_CAUTION, 10, caution when wind > this
  WIND_SEVERE, 15, severe when wind > this
  WIND_EMERG, 20, emergency when wind > this
  TEMP_SEVERE, 35, severe when temperature < -this or > this
  TEMP_EMERG, 40, emergency when temperature < -this or > this
  CNT_W, 8, emergency-entry counter width
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
  CLK  in  1  clock, rising edge
  RST  in  1  reset, asynchronous, active-high
  sample_valid  in  1  sensor inputs valid this cycle
  thunderstorm  in  1  thunderstorm flag
  wind  in  WIND_W  wind speed
  visibility  in  2  0 clear, 1 reduced, 2 poor, 3 none
  temperature  in  TEMP_W  signed temperature
  ack  in  1  crew acknowledge of emergency (single-cycle pulse)
  state  out  2  0 NORMAL, 1 CAUTION, 2 SEVERE, 3 EMERGENCY
  severe_weather  out  1  state >= SEVERE
  emergency_landing_alert  out  1  state == EMERGENCY
  state_changed  out  1  one-cycle pulse the cycle after any state change
  emerg_count  out  CNT_W  saturating count of EMERGENCY entries

Function
REQ-003 Each valid sample SHALL classify to a level: EMERGENCY if temp < -TEMP_EMERG, temp > TEMP_EMERG or wind > WIND_EMERG; else SEVERE if thunderstorm, temp < -TEMP_SEVERE, temp > TEMP_SEVERE, wind > WIND_SEVERE or visibility==3; else CAUTION if wind > WIND_CAUTION or visibility in {1,2}; else NORMAL.
REQ-004 Temperature comparisons SHALL be signed; thresholds SHALL be sign-extended to TEMP_W; boundary values (e.g. temp == 35, wind == 15) SHALL NOT trigger the higher level.
REQ-005 Cycles with sample_valid=0 SHALL hold state, outputs and debounce counter unchanged.
REQ-006 Escalation: classified level > state SHALL load state with classified level directly (levels may be skipped), one cycle latency, and clear the debounce counter.
REQ-007 De-escalation from NORMAL..SEVERE: classified level < state SHALL increment the debounce counter; on the DEBOUNCE-th consecutive such sample state SHALL drop by exactly one level and the counter SHALL clear.
REQ-008 Classified level == state SHALL clear the debounce counter.
REQ-009 EMERGENCY SHALL NOT de-escalate by debounce; exit governed by REQ-015/016.
REQ-010 severe_weather and emergency_landing_alert SHALL be registered and consistent with state every cycle.
REQ-011 emerg_count SHALL increment on each entry into EMERGENCY and saturate at 2^CNT_W-1.
REQ-012 ack outside EMERGENCY SHALL be ignored.

Reset
REQ-013 RST high SHALL asynchronously force state=NORMAL, all outputs 0, debounce counter 0, emerg_count 0, including mid-debounce.
REQ-014 First rising CLK after RST release SHALL evaluate normally.

Configuration
REQ-015 With ENV_SUP_ACK_EN defined: in EMERGENCY, ack=1 together with sample_valid=1 and classified level < EMERGENCY SHALL move state to SEVERE and clear the counter; ack with an EMERGENCY-class sample or sample_valid=0 SHALL be ignored.
REQ-016 Without ENV_SUP_ACK_EN: EMERGENCY SHALL be absorbing until RST; ack port SHALL remain present and unused.

Structure
REQ-017 Package env_sup_pkg SHALL hold the state/level enum typedef and default threshold constants.
REQ-018 Sub-module env_classifier SHALL implement REQ-003/004 combinationally; env_cond_supervisor holds FSM, debounce and counter.

Verification (DEBOUNCE=3, defaults)
REQ-019 NORMAL, valid sample wind=12 -> state=1 next cycle, state_changed=1 one cycle.
REQ-020 NORMAL, valid temp=-36 -> state=2, severe_weather=1; then temp=-41 -> state=3, alert=1, emerg_count=1.
REQ-021 SEVERE, three valid clear samples with one sample_valid=0 gap -> state=1 after third; clear, clear, wind=16, clear -> stays 2.
REQ-022 EMERGENCY, ack with wind=25 -> stays 3; ack with clear sample -> state=2 (macro on) / stays 3 (macro off).
REQ-023 RST asserted mid-debounce in SEVERE, not on clock edge -> all outputs 0 immediately.
REQ-024 Boundaries: wind=15, temp=35, temp=-35 -> CAUTION (wind>10), not SEVERE; wind=10, visibility=0 -> NORMAL.
